// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed little-endian program into IMem.
// Clears IMem to NOP first and holds the CPU in reset until the load is done.
`timescale 1ns/1ps

module imem_loader #(
    parameter int          DEPTH  = 256,
    parameter int          ADDR_W = 8,
    parameter logic [31:0] NOP    = 32'h0000_0013
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        HDR0,
        HDR1,
        DATA,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0]       DEPTH_W  = 17'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

    state_t      st;
    logic [15:0] n_words;
    logic [1:0]  byte_cnt;
    logic [31:0] shift;

    logic        accept;
    logic [15:0] hdr_n;
    logic [15:0] wl_next;

    assign accept  = in_valid && in_ready;
    assign hdr_n   = {in_data, n_words[7:0]};
    assign wl_next = words_loaded + 16'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st           <= IDLE;
            n_words      <= '0;
            byte_cnt     <= '0;
            shift        <= '0;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            unique case (st)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        st           <= CLEAR;
                        imem_we      <= 1'b1;
                        imem_addr    <= '0;
                        imem_wdata   <= NOP;
                        words_loaded <= '0;
                        byte_cnt     <= '0;
                        cpu_reset    <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (imem_addr == LAST_ADR) begin
                        st       <= HDR0;
                        imem_we  <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        imem_addr <= imem_addr + 1'b1;
                    end
                end
                HDR0: begin
                    if (accept) begin
                        n_words[7:0] <= in_data;
                        st           <= HDR1;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        n_words <= hdr_n;
                        if (hdr_n == 16'd0) begin
                            st        <= DONE;
                            in_ready  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else if ({1'b0, hdr_n} > DEPTH_W) begin
                            st       <= ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            st <= DATA;
                        end
                    end
                end
                DATA: begin
                    // a write cycle stalls the stream for one cycle
                    if (imem_we) begin
                        imem_we      <= 1'b0;
                        words_loaded <= wl_next;
                        if (wl_next == n_words) begin
                            st        <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            in_ready <= 1'b1;
                        end
                    end else if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shift[{byte_cnt, 3'b000} +: 8] <= in_data;
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= words_loaded[ADDR_W-1:0];
                            imem_wdata <= {in_data, shift[23:0]};
                            in_ready   <= 1'b0;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table vectors, timing sequences and random loads
// checked against an IMem image model built from the load rules.
`timescale 1ns/1ps

module tb_imem_loader;

    localparam int          DEPTH  = 256;
    localparam int          ADDR_W = 8;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       words_loaded;

    imem_loader #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .NOP(NOP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset),
        .busy(busy),
        .done(done),
        .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [DEPTH];
    int          wr_count = 0;

    always @(posedge clock) begin
        if (imem_we) begin
            mem[imem_addr] <= imem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    logic [31:0] prog    [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    typedef struct {
        int n;
        int maxgap;
        bit exp_done;
        bit exp_err;
        int exp_wl;
    } vec_t;

    vec_t vt [7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit n_ok(input int n);
        return n >= 1 && n <= DEPTH;
    endfunction

    task automatic model_load(input int n);
        for (int i = 0; i < DEPTH; i++)
            ref_mem[i] = (n_ok(n) && i < n) ? prog[i] : NOP;
    endtask

    function automatic int mem_bad();
        int b = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== ref_mem[i]) b++;
        return b;
    endfunction

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) check("ready_timeout", 32'(in_ready), 1);
    endtask

    // returns at the negedge following the accepting edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        repeat (gap) @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 64; i++) begin
            if (in_ready) begin
                @(posedge clock);
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (ok) @(negedge clock);
        else check("byte_timeout", 32'(in_ready), 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 16; i++) begin
            if (done || err) break;
            @(negedge clock);
        end
    endtask

    task automatic do_load(input int n, input int maxgap);
        model_load(n);
        pulse_start();
        wait_ready();
        send_byte(8'(n), 0);
        send_byte(8'(n >> 8), 0);
        if (n_ok(n))
            for (int w = 0; w < n; w++)
                for (int k = 0; k < 4; k++)
                    send_byte(prog[w][8*k +: 8],
                              $urandom_range(maxgap, 0));
        wait_end();
    endtask

    task automatic check_load(input int n, input bit ed, input bit ee,
                              input int ewl, input int base);
        check("done", 32'(done), 32'(ed));
        check("err", 32'(err), 32'(ee));
        check("cpu_reset", 32'(cpu_reset), 32'(!ed));
        check("in_ready_end", 32'(in_ready), 0);
        check("words_loaded", 32'(words_loaded), 32'(ewl));
        check("write_count", 32'(wr_count - base),
              32'(DEPTH + (n_ok(n) ? n : 0)));
        check("imem_image", 32'(mem_bad()), 0);
    endtask

    initial begin
        int base;
        int n;

        prog[0] = 32'h00500093;
        prog[1] = 32'h00300113;
        prog[2] = 32'h002081B3;
        prog[3] = 32'h40208233;
        prog[4] = 32'h023082B3;
        prog[5] = 32'h06400313;
        prog[6] = 32'h006283B3;
        prog[7] = 32'h00502023;
        for (int i = 8; i < DEPTH; i++) prog[i] = $urandom;

        vt[0] = '{3,    0, 1'b1, 1'b0, 3};
        vt[1] = '{8,    3, 1'b1, 1'b0, 8};
        vt[2] = '{0,    0, 1'b1, 1'b0, 0};
        vt[3] = '{257,  0, 1'b0, 1'b1, 0};
        vt[4] = '{1,    2, 1'b1, 1'b0, 1};
        vt[5] = '{256,  1, 1'b1, 1'b0, 256};
        vt[6] = '{1000, 0, 1'b0, 1'b1, 0};

        // reset, then idle
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("rst_cpu_reset", 32'(cpu_reset), 1);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_imem_we", 32'(imem_we), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_flags", {29'd0, busy, done, err}, 0);
        check("rst_wl", 32'(words_loaded), 0);

        // clear timing, then an empty program
        model_load(0);
        base = wr_count;
        pulse_start();
        check("clr_first_we", 32'(imem_we), 1);
        check("clr_first_addr", 32'(imem_addr), 0);
        check("clr_first_data", imem_wdata, NOP);
        check("clr_busy", 32'(busy), 1);
        repeat (DEPTH - 1) @(negedge clock);
        check("clr_last_addr", 32'(imem_addr), DEPTH - 1);
        check("clr_last_we", 32'(imem_we), 1);
        check("clr_last_rdy", 32'(in_ready), 0);
        @(negedge clock);
        check("hdr_ready", 32'(in_ready), 1);
        check("hdr_we", 32'(imem_we), 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("n0_done", 32'(done), 1);
        check("n0_cpu_reset", 32'(cpu_reset), 0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (5) @(negedge clock);
        check("n0_no_accept", 32'(in_ready), 0);
        in_valid = 1'b0;
        check("n0_writes", 32'(wr_count - base), DEPTH);
        check("n0_image", 32'(mem_bad()), 0);

        // header rejection timing
        model_load(257);
        pulse_start();
        wait_ready();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("hdr_err", 32'(err), 1);
        check("hdr_err_rdy", 32'(in_ready), 0);
        check("hdr_err_cpu", 32'(cpu_reset), 1);
        check("hdr_err_img", 32'(mem_bad()), 0);

        // table vectors
        for (int v = 0; v < 7; v++) begin
            base = wr_count;
            do_load(vt[v].n, vt[v].maxgap);
            check_load(vt[v].n, vt[v].exp_done, vt[v].exp_err,
                       vt[v].exp_wl, base);
        end

        // reset in the middle of a word
        pulse_start();
        wait_ready();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h03, 0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_cpu", 32'(cpu_reset), 1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_rdy", 32'(in_ready), 0);
        check("mid_rst_wl", 32'(words_loaded), 0);
        @(negedge clock);
        reset = 1'b0;

        // fresh load of one word with last-byte timing
        prog[0] = 32'h06400313;
        model_load(1);
        base = wr_count;
        pulse_start();
        wait_ready();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 4; k++) send_byte(prog[0][8*k +: 8], 0);
        check("w_we", 32'(imem_we), 1);
        check("w_addr", 32'(imem_addr), 0);
        check("w_data", imem_wdata, 32'h06400313);
        check("w_rdy", 32'(in_ready), 0);
        check("w_done_early", 32'(done), 0);
        @(negedge clock);
        check("w_done", 32'(done), 1);
        check("w_cpu", 32'(cpu_reset), 0);
        check("w_wl", 32'(words_loaded), 1);
        check("w_we_single", 32'(imem_we), 0);
        check("w_image", 32'(mem_bad()), 0);
        check("w_writes", 32'(wr_count - base), DEPTH + 1);

        // random programs with random stalls
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(24, 1);
            for (int i = 0; i < n; i++) prog[i] = $urandom;
            base = wr_count;
            do_load(n, 3);
            check_load(n, 1'b1, 1'b0, n, base);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
